gate_tt_reader: RTL and testbench

//  Sequential truth-table reader for the combinational synthesized gate netlists (4-in, 1-out NOR/NOT

---
 rtl/gate_tt_pkg.sv | 18 +
 rtl/gate_tt_settle_timer.sv | 27 ++
 rtl/gate_tt_reader.sv | 127 ++++++++++++
 tb/tb_gate_tt_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table reader.
package gate_tt_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StDone
   } tt_state_e;

   localparam int unsigned DefNIn       = 4;
   localparam int unsigned DefSettleCyc = 2;

   function automatic int unsigned tt_width(input int unsigned n_in);
      return 32'd1 << n_in;
   endfunction

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Loadable down-counter that times the settle interval after each new input vector.
module gate_tt_settle_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   // Flags the cycle in which the count steps down to zero.
   assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/gate_tt_reader.sv
// Sweeps all input vectors through a gate and assembles its hex truth table (MSB = vector 0).
// Optional TT_CHECK_EN adds exp_tt/match for comparing against an expected table.
module gate_tt_reader
   import gate_tt_pkg::*;
#(
   parameter int unsigned N_IN       = DefNIn,
   parameter int unsigned SETTLE_CYC = DefSettleCyc,
   localparam int unsigned TT_W      = tt_width(N_IN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] tt_out,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out
`ifdef TT_CHECK_EN
   ,
   input  logic [TT_W-1:0] exp_tt,
   output logic            match
`endif
);

   localparam int unsigned     CntW       = $clog2(SETTLE_CYC + 2);
   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYC);
   localparam logic [N_IN-1:0] IdxLast    = N_IN'(TT_W - 1);
   localparam tt_state_e       VecState   = (SETTLE_CYC == 0) ? StSample : StSettle;

   tt_state_e       state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [TT_W-1:0] shreg_q, shreg_d;
   logic [TT_W-1:0] tt_q, tt_d;
   logic            timer_load, timer_expired;

`ifdef TT_CHECK_EN
   logic [TT_W-1:0] exp_q, exp_d;
   logic            match_q, match_d;
`endif

   gate_tt_settle_timer #(
      .W(CntW)
   ) u_settle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (timer_load),
      .value  (SettleLoad),
      .expired(timer_expired)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      tt_d       = tt_q;
      timer_load = 1'b0;
`ifdef TT_CHECK_EN
      exp_d      = exp_q;
      match_d    = match_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               idx_d      = '0;
               shreg_d    = '0;
               timer_load = 1'b1;
               state_d    = VecState;
`ifdef TT_CHECK_EN
               exp_d      = exp_tt;
`endif
            end else begin
               state_d = StIdle;
            end
         end
         StSettle: begin
            if (timer_expired) state_d = StSample;
         end
         StSample: begin
            shreg_d = {shreg_q[TT_W-2:0], dut_out};
            if (idx_q == IdxLast) begin
               // Result is published on entry to DONE so it is valid alongside the done pulse.
               tt_d    = shreg_d;
               state_d = StDone;
`ifdef TT_CHECK_EN
               match_d = (shreg_d == exp_q);
`endif
            end else begin
               idx_d      = idx_q + N_IN'(1);
               timer_load = 1'b1;
               state_d    = VecState;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         shreg_q <= '0;
         tt_q    <= '0;
`ifdef TT_CHECK_EN
         exp_q   <= '0;
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tt_q    <= tt_d;
`ifdef TT_CHECK_EN
         exp_q   <= exp_d;
         match_q <= match_d;
`endif
      end
   end

   assign busy   = (state_q == StSettle) || (state_q == StSample);
   assign done   = (state_q == StDone);
   assign tt_out = tt_q;
   assign dut_in = busy ? idx_q : '0;
`ifdef TT_CHECK_EN
   assign match  = match_q;
`endif

endmodule

// File: tb/tb_gate_tt_reader.sv
// Bench for gate_tt_reader: three instances (settle 2, 0, 5) driven by a configurable gate model.
`timescale 1ns/1ps
module tb_gate_tt_reader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic [15:0] tt_a, tt_b, tt_c;
   logic [3:0]  in_a, in_b, in_c;
   logic        out_a, out_b, out_c;

   // Gate model: mode 0 = table lookup (vector v -> bit 15-v), mode 1 = NOR of masked inputs ^ inv.
   int          mode = 0;
   logic [15:0] gate_tt = 16'hCBD6;
   logic [3:0]  mask = 4'h0;
   logic        inv = 1'b0;

   assign out_a = (mode == 0) ? gate_tt[4'd15 - in_a] : ((~|(in_a & mask)) ^ inv);
   assign out_b = (mode == 0) ? gate_tt[4'd15 - in_b] : ((~|(in_b & mask)) ^ inv);
   assign out_c = (mode == 0) ? gate_tt[4'd15 - in_c] : ((~|(in_c & mask)) ^ inv);

`ifdef TT_CHECK_EN
   logic [15:0] exp_tt = 16'h0;
   logic        match_a, match_b, match_c;
`endif

   gate_tt_reader #(.N_IN(4), .SETTLE_CYC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
      .tt_out(tt_a), .dut_in(in_a), .dut_out(out_a)
`ifdef TT_CHECK_EN
      , .exp_tt(exp_tt), .match(match_a)
`endif
   );

   gate_tt_reader #(.N_IN(4), .SETTLE_CYC(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .tt_out(tt_b), .dut_in(in_b), .dut_out(out_b)
`ifdef TT_CHECK_EN
      , .exp_tt(exp_tt), .match(match_b)
`endif
   );

   gate_tt_reader #(.N_IN(4), .SETTLE_CYC(5)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
      .tt_out(tt_c), .dut_in(in_c), .dut_out(out_c)
`ifdef TT_CHECK_EN
      , .exp_tt(exp_tt), .match(match_c)
`endif
   );

   int checks = 0;
   int errors = 0;

   function automatic logic ref_gate(input int v);
      logic [3:0] vv;
      vv = 4'(v);
      if (mode == 0) return gate_tt[15 - v];
      return (~|(vv & mask)) ^ inv;
   endfunction

   // Vector i is the i-th sample, so it lands at bit 15-i.
   function automatic logic [15:0] ref_table();
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[15 - i] = ref_gate(i);
      return t;
   endfunction

   function automatic int settle_of(input int which);
      return (which == 0) ? 2 : (which == 1) ? 0 : 5;
   endfunction

   task automatic set_start(input int which, input logic v);
      case (which)
         0: start_a = v;
         1: start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic get(input int which, output logic d, output logic b, output logic [3:0] di,
                      output logic [15:0] tt);
      case (which)
         0: begin d = done_a; b = busy_a; di = in_a; tt = tt_a; end
         1: begin d = done_b; b = busy_b; di = in_b; tt = tt_b; end
         default: begin d = done_c; b = busy_c; di = in_c; tt = tt_c; end
      endcase
   endtask

   // Pulses start for one cycle (cycle 0) and returns the cycle at which done was seen (-1 if never),
   // the captured table and the number of cycles where busy/dut_in disagreed with the schedule.
   task automatic run_sweep(input int which, output int lat, output logic [15:0] tt,
                            output int step_err);
      int n, s;
      logic d, b;
      logic [3:0] di;
      s = settle_of(which);
      step_err = 0;
      lat = -1;
      n = 0;
      @(posedge clk); #1 set_start(which, 1'b1);
      @(posedge clk); #1 set_start(which, 1'b0);
      while (lat < 0 && n < 400) begin
         @(negedge clk);
         n++;
         get(which, d, b, di, tt);
         if (d) lat = n;
         else if (n <= 16 * (s + 1)) begin
            if (b !== 1'b1 || di !== 4'((n - 1) / (s + 1))) step_err++;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b%b%b want 000", busy_a, busy_b, busy_c); end
      checks++; if (done_a !== 1'b0 || done_b !== 1'b0 || done_c !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b%b%b want 000", done_a, done_b, done_c); end
      checks++; if (tt_a !== 16'h0 || tt_b !== 16'h0 || tt_c !== 16'h0) begin
         errors++; $display("FAIL reset_tt: got %h %h %h want 0", tt_a, tt_b, tt_c); end
      checks++; if (in_a !== 4'h0 || in_b !== 4'h0 || in_c !== 4'h0) begin
         errors++; $display("FAIL reset_dut_in: got %h %h %h want 0", in_a, in_b, in_c); end
`ifdef TT_CHECK_EN
      checks++; if (match_a !== 1'b0) begin
         errors++; $display("FAIL reset_match: got %b want 0", match_a); end
`endif
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cbd6();
      int lat, se;
      logic [15:0] tt;
      mode = 0; gate_tt = 16'hCBD6;
      run_sweep(0, lat, tt, se);
      checks++; if (lat !== 49) begin errors++; $display("FAIL cbd6_latency: got %0d want 49", lat); end
      checks++; if (tt !== 16'hCBD6) begin errors++; $display("FAIL cbd6_tt: got %h want cbd6", tt); end
      checks++; if (se !== 0) begin errors++; $display("FAIL cbd6_steps: got %0d bad cycles want 0", se); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL cbd6_busy_at_done: got %b want 0", busy_a); end
   endtask

   task automatic test_projections();
      int lat, se;
      logic [15:0] tt;
      mode = 1; mask = 4'h0; inv = 1'b0;
      run_sweep(0, lat, tt, se);
      checks++; if (tt !== 16'hFFFF) begin errors++; $display("FAIL const1_tt: got %h want ffff", tt); end
      mask = 4'h8; inv = 1'b1;
      run_sweep(0, lat, tt, se);
      checks++; if (tt !== 16'h00FF) begin errors++; $display("FAIL in0_tt: got %h want 00ff", tt); end
      mask = 4'h1; inv = 1'b1;
      run_sweep(0, lat, tt, se);
      checks++; if (tt !== 16'h5555) begin errors++; $display("FAIL in3_tt: got %h want 5555", tt); end
   endtask

   task automatic test_back_to_back();
      int n, d1, d2;
      logic [15:0] first_tt;
      mode = 0; gate_tt = 16'h1E3C;
      d1 = -1; d2 = -1; n = 0; first_tt = 16'h0;
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk);
      while (d2 < 0 && n < 300) begin
         @(negedge clk);
         n++;
         if (done_a) begin
            if (d1 < 0) begin d1 = n; first_tt = tt_a; end
            else begin d2 = n; start_a = 1'b0; end
         end
         if (n == 70) begin
            checks++; if (tt_a !== 16'h1E3C) begin
               errors++; $display("FAIL b2b_hold_mid: got %h want 1e3c", tt_a); end
         end
      end
      start_a = 1'b0;
      checks++; if (d1 !== 49) begin errors++; $display("FAIL b2b_first_done: got %0d want 49", d1); end
      checks++; if (d2 !== 98) begin errors++; $display("FAIL b2b_second_done: got %0d want 98", d2); end
      checks++; if (first_tt !== 16'h1E3C || tt_a !== 16'h1E3C) begin
         errors++; $display("FAIL b2b_tt: got %h/%h want 1e3c", first_tt, tt_a); end
      repeat (3) @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got busy %b want 0", busy_a); end
   endtask

   task automatic test_start_while_busy();
      int n, lat;
      logic [15:0] prev;
      mode = 1; mask = 4'h6; inv = 1'b0;
      prev = tt_a;
      lat = -1; n = 0;
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      while (lat < 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 10) start_a = 1'b1;
         if (n == 11) start_a = 1'b0;
         if (n == 30) begin
            checks++; if (tt_a !== prev) begin
               errors++; $display("FAIL busy_old_result: got %h want %h", tt_a, prev); end
         end
         if (done_a) lat = n;
      end
      checks++; if (lat !== 49) begin errors++; $display("FAIL busy_start_latency: got %0d want 49", lat); end
      checks++; if (tt_a !== ref_table()) begin
         errors++; $display("FAIL busy_start_tt: got %h want %h", tt_a, ref_table()); end
      repeat (2) @(negedge clk);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_start_no_rerun: got %b want 0", busy_a); end
   endtask

   task automatic test_reset_mid_sweep();
      int n, dones, lat, se;
      logic [15:0] tt;
      mode = 0; gate_tt = 16'hA5C3;
      n = 0;
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      while (n < 20) begin @(negedge clk); n++; end
      rst_n = 1'b0;
      #1;
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ctrl: got busy %b done %b want 0 0", busy_a, done_a); end
      checks++; if (in_a !== 4'h0 || tt_a !== 16'h0) begin
         errors++; $display("FAIL rst_mid_data: got dut_in %h tt %h want 0 0", in_a, tt_a); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (60) begin @(negedge clk); if (done_a || busy_a) dones++; end
      checks++; if (dones !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", dones); end
      run_sweep(0, lat, tt, se);
      checks++; if (lat !== 49 || tt !== 16'hA5C3) begin
         errors++; $display("FAIL rst_mid_rerun: got lat %0d tt %h want 49 a5c3", lat, tt); end
   endtask

   task automatic test_settle_variants();
      int lat, se;
      logic [15:0] tt;
      mode = 0; gate_tt = 16'hCBD6;
      run_sweep(1, lat, tt, se);
      checks++; if (lat !== 17) begin errors++; $display("FAIL settle0_latency: got %0d want 17", lat); end
      checks++; if (tt !== 16'hCBD6) begin errors++; $display("FAIL settle0_tt: got %h want cbd6", tt); end
      checks++; if (se !== 0) begin errors++; $display("FAIL settle0_steps: got %0d bad cycles want 0", se); end
      run_sweep(2, lat, tt, se);
      checks++; if (lat !== 97) begin errors++; $display("FAIL settle5_latency: got %0d want 97", lat); end
      checks++; if (tt !== 16'hCBD6 || se !== 0) begin
         errors++; $display("FAIL settle5_result: got tt %h steps %0d want cbd6 0", tt, se); end
   endtask

   task automatic test_random();
      int lat, se, which;
      logic [15:0] tt, expv;
      for (int r = 0; r < 9; r++) begin
         which   = r % 3;
         mode    = int'($urandom_range(0, 1));
         gate_tt = 16'($urandom);
         mask    = 4'($urandom_range(0, 15));
         inv     = 1'($urandom_range(0, 1));
         expv    = ref_table();
         run_sweep(which, lat, tt, se);
         checks++; if (tt !== expv) begin
            errors++; $display("FAIL rand%0d_tt: got %h want %h", r, tt, expv); end
         checks++; if (lat !== 16 * (settle_of(which) + 1) + 1 || se !== 0) begin
            errors++; $display("FAIL rand%0d_timing: got lat %0d steps %0d want %0d 0", r, lat, se,
                               16 * (settle_of(which) + 1) + 1); end
      end
   endtask

`ifdef TT_CHECK_EN
   task automatic test_match();
      int lat, se;
      logic [15:0] tt;
      mode = 0; gate_tt = 16'hCBD6;
      exp_tt = 16'hCBD6;
      run_sweep(0, lat, tt, se);
      checks++; if (match_a !== 1'b1) begin errors++; $display("FAIL match_hit: got %b want 1", match_a); end
      exp_tt = 16'hCBD7;
      run_sweep(0, lat, tt, se);
      checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL match_miss: got %b want 0", match_a); end
   endtask
`endif

   initial begin
      test_reset();
      test_cbd6();
      test_projections();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid_sweep();
      test_settle_variants();
      test_random();
`ifdef TT_CHECK_EN
      test_match();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
